// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and memory depth.
package mem_pkg;

    localparam int MEM_WORDS_DEF = 64;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LEER     = 3'd1,
        ST_ESCRIBIR = 3'd2,
        ST_RESP     = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    // Size encoding is illegal, or the low address bits break natural alignment.
    function automatic logic bad_size_align(input logic [1:0] size, input logic [1:0] low);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return low[0];
            SZ_WORD: return low != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/unidad_carga_almacen_if.sv
// Pipeline request/response and data-memory signals of the load/store unit.
interface unidad_carga_almacen_if;
    logic        req_valid;
    logic        req_ready;
    logic        op_load;
    logic        op_store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_enw;
    logic        mem_enr;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, op_load, op_store, size, sign_ext, addr, wdata, mem_rdata,
        output req_ready, rsp_valid, err, rdata, mem_addr, mem_wdata, mem_enw, mem_enr
    );

    modport master (
        output req_valid, op_load, op_store, size, sign_ext, addr, wdata, mem_rdata,
        input  req_ready, rsp_valid, err, rdata, mem_addr, mem_wdata, mem_enw, mem_enr
    );
endinterface

// File: rtl/unidad_carga_almacen_alineador_bytes.sv
// Little-endian lane extraction with sign/zero extension, and sub-word store merge.
module alineador_bytes
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_shift = {lane, 3'b000};
    assign half_shift = {lane[1], 4'b0000};
    assign half_val   = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (lane)
            2'd0:    byte_val = word[7:0];
            2'd1:    byte_val = word[15:8];
            2'd2:    byte_val = word[23:16];
            default: byte_val = word[31:24];
        endcase
    end

    always_comb begin
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_val[7]}}, byte_val};
            SZ_HALF: load_data = {{16{sign_ext & half_val[15]}}, half_val};
            default: load_data = word;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the read word is kept.
    always_comb begin
        case (size)
            SZ_BYTE: merged = (word & ~(32'h0000_00FF << byte_shift)) |
                              ({24'h0, wdata[7:0]} << byte_shift);
            SZ_HALF: merged = (word & ~(32'h0000_FFFF << half_shift)) |
                              ({16'h0, wdata[15:0]} << half_shift);
            default: merged = wdata;
        endcase
    end
endmodule

// File: rtl/unidad_carga_almacen.sv
// Load/store unit: one access at a time, byte/halfword/word, read-modify-write for sub-word stores.
module unidad_carga_almacen
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    unidad_carga_almacen_if.slave  bus
);
    state_t      state;
    logic [1:0]  cap_lane;
    logic [1:0]  cap_size;
    logic        cap_sign;
    logic        cap_store;
    logic [31:0] cap_wdata;
    logic [31:0] rdata_hold;
    logic [31:0] word_addr;
    logic [31:0] word_out;
    logic        acc_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    always_comb begin
        acc_err = 1'b0;
        if (bus.op_load == bus.op_store)
            acc_err = 1'b1;
        if (bad_size_align(bus.size, bus.addr[1:0]))
            acc_err = 1'b1;
        if ({2'b00, bus.addr[31:2]} >= 32'(MEM_WORDS))
            acc_err = 1'b1;
    end

    alineador_bytes u_alineador (
        .word      (bus.mem_rdata),
        .lane      (cap_lane),
        .size      (cap_size),
        .sign_ext  (cap_sign),
        .wdata     (cap_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cap_lane   <= '0;
            cap_size   <= '0;
            cap_sign   <= 1'b0;
            cap_store  <= 1'b0;
            cap_wdata  <= '0;
            rdata_hold <= '0;
            word_addr  <= '0;
            word_out   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        cap_lane  <= bus.addr[1:0];
                        cap_size  <= bus.size;
                        cap_sign  <= bus.sign_ext;
                        cap_store <= bus.op_store;
                        cap_wdata <= bus.wdata;
                        if (acc_err) begin
                            state <= ST_ERROR;
                        end else begin
                            word_addr <= {2'b00, bus.addr[31:2]};
                            // Full-word stores skip the read; nothing needs merging.
                            if (bus.op_store && bus.size == SZ_WORD) begin
                                word_out <= bus.wdata;
                                state    <= ST_ESCRIBIR;
                            end else begin
                                state <= ST_LEER;
                            end
                        end
                    end
                end
                ST_LEER: begin
                    if (cap_store) begin
                        word_out <= merged;
                        state    <= ST_ESCRIBIR;
                    end else begin
                        rdata_hold <= load_data;
                        state      <= ST_RESP;
                    end
                end
                ST_ESCRIBIR: state <= ST_RESP;
                ST_RESP:     state <= ST_IDLE;
                ST_ERROR:    state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Enables and response flags decode straight from the state, so reset kills them at once.
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.mem_enr   = (state == ST_LEER);
    assign bus.mem_enw   = (state == ST_ESCRIBIR);
    assign bus.rsp_valid = (state == ST_RESP) || (state == ST_ERROR);
    assign bus.err       = (state == ST_ERROR);
    assign bus.rdata     = rdata_hold;
    assign bus.mem_addr  = word_addr;
    assign bus.mem_wdata = word_out;
endmodule

// File: tb/tb_unidad_carga_almacen.sv
// Bench for unidad_carga_almacen: directed vector table, random accesses vs. reference model, reset abort.
module tb_unidad_carga_almacen;
    localparam int MW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unidad_carga_almacen_if bus ();

    unidad_carga_almacen #(.MEM_WORDS(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [MW];
    logic        pre_en = 1'b0;
    int          pre_idx = 0;
    logic [31:0] pre_val = '0;

    assign bus.mem_rdata = (bus.mem_addr < MW) ? mem[bus.mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_idx] <= pre_val;
        else if (bus.mem_enw && bus.mem_addr < MW)
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end

    int total = 0;
    int bad = 0;
    logic [31:0] held_rdata = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Presents one request, keeps req_valid high with scrambled inputs while busy.
    task automatic access(input bit ld, input bit st, input bit [1:0] sz, input bit sx,
                          input bit [31:0] a, input bit [31:0] wd,
                          output bit g_err, output int g_lat, output int g_enr, output int g_enw);
        bit done;
        @(negedge clk);
        chk("ready_before_req", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.op_load = ld; bus.op_store = st; bus.size = sz;
        bus.sign_ext = sx; bus.addr = a; bus.wdata = wd;
        @(posedge clk);
        done = 0; g_err = 0; g_lat = 0; g_enr = 0; g_enw = 0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            g_enr += int'(bus.mem_enr);
            g_enw += int'(bus.mem_enw);
            if (bus.mem_enr && bus.mem_enw) begin
                bad++;
                $display("FAIL enables_together cycle=%0d got=both want=exclusive", c);
            end
            if (bus.rsp_valid) begin
                done = 1; g_lat = c; g_err = bus.err;
                bus.req_valid = 1'b0;
            end else begin
                bus.addr = $urandom; bus.wdata = $urandom; bus.size = 2'($urandom);
                bus.sign_ext = 1'($urandom); bus.op_load = 1'($urandom); bus.op_store = 1'($urandom);
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL rsp_timeout got=none want=rsp_valid");
            bus.req_valid = 1'b0;
        end
    endtask

    // Reference: outcome of an access from its architectural rules.
    function automatic void model(input bit ld, input bit st, input bit [1:0] sz, input bit sx,
                                  input bit [31:0] a, input bit [31:0] wd, input bit [31:0] old,
                                  output bit e, output int lat, output bit [31:0] rd,
                                  output bit [31:0] nw, output int enr, output int enw);
        int unsigned sh;
        bit [31:0] part;
        e = (ld == st) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
            (sz == 2'd2 && a[1:0] != 2'd0) || ((a >> 2) >= MW);
        nw = old; rd = 32'h0;
        if (e) begin
            lat = 1; enr = 0; enw = 0;
            return;
        end
        sh = 8 * int'(a[1:0]);
        if (ld) begin
            lat = 2; enr = 1; enw = 0;
            if (sz == 2'd0) begin
                part = (old >> sh) % 256;
                if (sx && part >= 128) part = part + 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                part = (old >> sh) % 65536;
                if (sx && part >= 32768) part = part + 32'hFFFF_0000;
            end else begin
                part = old;
            end
            rd = part;
        end else if (sz == 2'd2) begin
            lat = 2; enr = 0; enw = 1; nw = wd;
        end else begin
            lat = 3; enr = 1; enw = 1;
            if (sz == 2'd0)
                nw = old - (((old >> sh) % 256) << sh) + ((wd % 256) << sh);
            else
                nw = old - (((old >> sh) % 65536) << sh) + ((wd % 65536) << sh);
        end
    endfunction

    typedef struct {
        bit        ld, st;
        bit [1:0]  sz;
        bit        sx;
        bit [31:0] a, wd;
        bit        pre;
        bit [31:0] pre_val;
        bit        e_err;
        int        e_lat, e_enr, e_enw;
        bit [31:0] e_rd, e_word;
    } vec_t;

    vec_t vt[15];

    initial begin
        bit g_err, m_err;
        int g_lat, g_enr, g_enw, m_lat, m_enr, m_enw;
        bit [31:0] m_rd, m_nw, old, a, wd;
        bit ld, st, sx;
        bit [1:0] sz;
        int idx;

        //         ld st sz   sx addr           wdata          pre pre_val        err lat enr enw rdata          word4
        vt[0]  = '{0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0,         0, 2, 0, 1, 32'h0,         32'hDEAD_BEEF};
        vt[1]  = '{1, 0, 2'd2, 0, 32'h10, 32'h0,         0, 32'h0,         0, 2, 1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[2]  = '{0, 1, 2'd0, 0, 32'h11, 32'h1234_56AB, 1, 32'h1122_3344, 0, 3, 1, 1, 32'h0,         32'h1122_AB44};
        vt[3]  = '{1, 0, 2'd0, 1, 32'h13, 32'h0,         1, 32'h80FF_0000, 0, 2, 1, 0, 32'hFFFF_FF80, 32'h80FF_0000};
        vt[4]  = '{1, 0, 2'd0, 0, 32'h13, 32'h0,         0, 32'h0,         0, 2, 1, 0, 32'h0000_0080, 32'h80FF_0000};
        vt[5]  = '{1, 0, 2'd1, 1, 32'h12, 32'h0,         0, 32'h0,         0, 2, 1, 0, 32'hFFFF_80FF, 32'h80FF_0000};
        vt[6]  = '{1, 0, 2'd1, 0, 32'h12, 32'h0,         0, 32'h0,         0, 2, 1, 0, 32'h0000_80FF, 32'h80FF_0000};
        vt[7]  = '{1, 0, 2'd1, 1, 32'h13, 32'h0,         0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h80FF_0000};
        vt[8]  = '{1, 0, 2'd2, 0, 32'h100, 32'h0,        0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h80FF_0000};
        vt[9]  = '{1, 1, 2'd2, 0, 32'h10, 32'h5555_5555, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h80FF_0000};
        vt[10] = '{0, 0, 2'd2, 0, 32'h10, 32'h0,         0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h80FF_0000};
        vt[11] = '{1, 0, 2'd3, 0, 32'h10, 32'h0,         0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h80FF_0000};
        vt[12] = '{0, 1, 2'd1, 0, 32'h12, 32'hFFFF_BEEF, 1, 32'h1122_3344, 0, 3, 1, 1, 32'h0,         32'hBEEF_3344};
        vt[13] = '{1, 0, 2'd0, 1, 32'h10, 32'h0,         0, 32'h0,         0, 2, 1, 0, 32'h0000_0044, 32'hBEEF_3344};
        vt[14] = '{0, 1, 2'd2, 0, 32'h11, 32'h0BAD_0BAD, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'hBEEF_3344};

        bus.req_valid = 1'b0; bus.op_load = 1'b0; bus.op_store = 1'b0; bus.size = 2'd0;
        bus.sign_ext = 1'b0; bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < MW; i++) mem[i] = 32'h0;

        // Reset values while rst_n is held low
        #12;
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_err",       {31'b0, bus.err},       32'd0);
        chk("rst_rdata",     bus.rdata,              32'd0);
        chk("rst_mem_addr",  bus.mem_addr,           32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,          32'd0);
        chk("rst_enables",   {30'b0, bus.mem_enr, bus.mem_enw}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            if (vt[i].pre) preload(4, vt[i].pre_val);
            access(vt[i].ld, vt[i].st, vt[i].sz, vt[i].sx, vt[i].a, vt[i].wd, g_err, g_lat, g_enr, g_enw);
            if (vt[i].ld && !vt[i].e_err) held_rdata = vt[i].e_rd;
            chk($sformatf("vec%0d_err", i),   {31'b0, g_err},   {31'b0, vt[i].e_err});
            chk($sformatf("vec%0d_lat", i),   32'(g_lat),       32'(vt[i].e_lat));
            chk($sformatf("vec%0d_enr", i),   32'(g_enr),       32'(vt[i].e_enr));
            chk($sformatf("vec%0d_enw", i),   32'(g_enw),       32'(vt[i].e_enw));
            chk($sformatf("vec%0d_rdata", i), bus.rdata,        held_rdata);
            chk($sformatf("vec%0d_word4", i), mem[4],           vt[i].e_word);
        end

        for (int i = 0; i < MW; i++) preload(i, $urandom);
        for (int n = 0; n < 200; n++) begin
            ld = 1'($urandom); st = ($urandom_range(0, 7) == 0) ? ld : !ld;
            sz = 2'($urandom); sx = 1'($urandom); wd = $urandom;
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4 * MW + 15));
            idx = int'(a >> 2);
            old = (idx < MW) ? mem[idx] : 32'h0;
            model(ld, st, sz, sx, a, wd, old, m_err, m_lat, m_rd, m_nw, m_enr, m_enw);
            access(ld, st, sz, sx, a, wd, g_err, g_lat, g_enr, g_enw);
            if (ld && !m_err) held_rdata = m_rd;
            chk($sformatf("rnd%0d_err", n),   {31'b0, g_err}, {31'b0, m_err});
            chk($sformatf("rnd%0d_lat", n),   32'(g_lat),     32'(m_lat));
            chk($sformatf("rnd%0d_enrw", n),  32'(g_enr * 2 + g_enw), 32'(m_enr * 2 + m_enw));
            chk($sformatf("rnd%0d_rdata", n), bus.rdata,      held_rdata);
            if (!m_err) chk($sformatf("rnd%0d_word", n), mem[idx], m_nw);
        end

        // Reset pulse during the write phase of a byte store aborts the write
        preload(5, 32'h5566_7788);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.op_load = 1'b0; bus.op_store = 1'b1; bus.size = 2'd0;
        bus.sign_ext = 1'b0; bus.addr = 32'h14; bus.wdata = 32'h99;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_enr",   {31'b0, bus.mem_enr}, 32'd1);
        @(negedge clk);
        chk("abort_enw",   {31'b0, bus.mem_enw}, 32'd1);
        chk("abort_wdata", bus.mem_wdata, 32'h5566_7799);
        chk("abort_addr",  bus.mem_addr,  32'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_enw_drop", {31'b0, bus.mem_enw},   32'd0);
        chk("abort_rsp",      {31'b0, bus.rsp_valid}, 32'd0);
        chk("abort_wdata_clr", bus.mem_wdata,         32'd0);
        chk("abort_addr_clr",  bus.mem_addr,          32'd0);
        chk("abort_rdata_clr", bus.rdata,             32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk("abort_mem_kept", mem[5], 32'h5566_7788);
        @(posedge clk) #1;
        chk("abort_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("abort_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);

        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, g_err, g_lat, g_enr, g_enw);
        chk("post_rst_err",   {31'b0, g_err}, 32'd0);
        chk("post_rst_lat",   32'(g_lat),     32'd2);
        chk("post_rst_rdata", bus.rdata,      32'h5566_7788);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/unidad_carga_almacen.md
UNIDAD_CARGA_ALMACEN -- requirements
Module: unidad_carga_almacen

Interface
REQ-001 Parameter MEM_WORDS, default 64, number of 32-bit words in the downstream data memory.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  pipeline presents an access this cycle.
REQ-005 req_ready  out  1  unit idle and accepting; high only in IDLE.
REQ-006 op_load / op_store  in  1 each  access type.
REQ-007 size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 sign_ext  in  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-009 addr  in  32  byte address; wdata  in  32  store data, right-justified.
REQ-010 rsp_valid  out  1  one-cycle completion pulse; err  out  1  qualifies rsp_valid as a faulted access.
REQ-011 rdata  out  32  extended load result.
REQ-012 mem_addr  out  32  word index (addr[31:2]); mem_wdata  out  32  word to write; mem_enw / mem_enr  out  1 each  memory enables; mem_rdata  in  32  combinational same-cycle read data.

Function
REQ-013 FSM states IDLE, LEER, ESCRIBIR, RESP, ERROR, held in one registered state variable.
REQ-014 Accept only when state is IDLE and req_valid=1; req_valid outside IDLE is ignored, never queued.
REQ-015 On acceptance, addr, size, sign_ext, wdata and op are captured; outputs thereafter depend only on captured values.
REQ-016 Error at acceptance, going to ERROR: op_load=op_store (both or neither), size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS.
REQ-017 ERROR: rsp_valid=1, err=1 for one cycle; no memory enable asserted; next state IDLE.
REQ-018 Load or sub-word store goes IDLE->LEER; word store goes IDLE->ESCRIBIR.
REQ-019 LEER: mem_enr=1 for exactly one cycle.
REQ-020 LEER, load: the addressed lane of mem_rdata is extended and registered into rdata; next state RESP.
REQ-021 LEER, sub-word store: the store lane is merged into mem_rdata, the merged word is registered; next state ESCRIBIR.
REQ-022 ESCRIBIR: mem_enw=1 for exactly one cycle, mem_addr and mem_wdata stable the whole cycle; next state RESP.
REQ-023 RESP: rsp_valid=1, err=0 for one cycle; next state IDLE.
REQ-024 Little-endian lanes: byte k occupies bits 8k+7:8k selected by addr[1:0]; halfword selected by addr[1].
REQ-025 mem_enr and mem_enw are decoded from the state register only; they are never high together; both are 0 in IDLE, RESP and ERROR.
REQ-026 Latency from acceptance cycle N: rsp_valid at N+2 for load and word store, N+3 for sub-word store, N+1 for error.
REQ-027 rdata changes only on load completion and holds its value otherwise; mem_addr and mem_wdata hold their last values when enables are low.

Reset
REQ-028 rst_n low immediately forces IDLE, including mid-access.
REQ-029 rst_n low immediately clears rsp_valid, err, rdata, mem_addr, mem_wdata, mem_enw and mem_enr to 0, aborting any pending write.
REQ-030 req_ready=1 from the first edge after rst_n deasserts.

Structure
REQ-031 Shared package mem_pkg holds size encodings, FSM state encoding and the MEM_WORDS default.
REQ-032 Lane extraction/extension and store merge live in one combinational sub-module, alineador_bytes.

Verification
REQ-033 Word store 0xDEADBEEF at 0x10, then word load 0x10 -> single mem_enw cycle at index 4; load rsp at N+2 with rdata=0xDEADBEEF.
REQ-034 Memory word 4 = 0x11223344, byte store 0xAB at 0x11 -> one mem_enr, then one mem_enw; word 4 = 0x1122AB44; rsp at N+3.
REQ-035 Word 4 = 0x80FF0000, byte load at 0x13 -> rdata 0xFFFFFF80 with sign_ext=1, 0x00000080 with sign_ext=0; halfword load at 0x12 with sign_ext=1 -> 0xFFFF80FF.
REQ-036 Halfword load at 0x13, word load at 0x100, op_load=op_store=1 -> each gives rsp_valid=1, err=1 at N+1 with no enable.
REQ-037 rst_n pulsed low during ESCRIBIR of a byte store -> mem_enw drops in the same cycle, memory word unchanged, no rsp_valid, req_ready=1 after release.
